// File: rtl/sata_pkg.sv
// Shared SATA link-layer definitions.
//   P_SOF / P_EOF / P_HOLD : primitive dwords used by the framer
//   FRAME_MAX_WORDS        : longest frame the framer will accept
//   CNT_W                  : width of frame word counters
//   arb_state_t            : transmit arbiter state encoding
package sata_pkg;

  localparam logic [31:0] P_SOF  = 32'h3737_B57C;
  localparam logic [31:0] P_EOF  = 32'hD5D5_B57C;
  localparam logic [31:0] P_HOLD = 32'hD5D5_AA7C;

  localparam int FRAME_MAX_WORDS = 4095;
  localparam int CNT_W           = 12;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PASS,
    ARB_DROP
  } arb_state_t;

endpackage

// File: rtl/satalnk_txarb.sv
// Frame-atomic two-source round-robin arbiter in front of the transmit framer.
// Source 0 carries register/command FISes, source 1 carries data FISes.
// Single-word frames are swallowed (o_err_short); frames longer than
// MAX_WORDS are cut with a forced TLAST and the remainder is drained
// (o_err_long).
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   S0_AXIS_*, S1_AXIS_*    source streams (TVALID/TREADY/TDATA/TLAST)
//   M_AXIS_*                stream to the framer, combinational pass-through
//   o_grant                 one-hot owner of the current frame, 0 when idle
//   o_err_short, o_err_long registered one-cycle error pulses
module satalnk_txarb
  import sata_pkg::*;
#(
  parameter int W            = 32,
  parameter int MAX_WORDS    = 2049,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         S0_AXIS_TVALID,
  output logic         S0_AXIS_TREADY,
  input  logic [W-1:0] S0_AXIS_TDATA,
  input  logic         S0_AXIS_TLAST,
  input  logic         S1_AXIS_TVALID,
  output logic         S1_AXIS_TREADY,
  input  logic [W-1:0] S1_AXIS_TDATA,
  input  logic         S1_AXIS_TLAST,
  output logic         M_AXIS_TVALID,
  input  logic         M_AXIS_TREADY,
  output logic [W-1:0] M_AXIS_TDATA,
  output logic         M_AXIS_TLAST,
  output logic [1:0]   o_grant,
  output logic         o_err_short,
  output logic         o_err_long
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);

  arb_state_t       state, state_nxt;
  logic             sel, sel_nxt;
  logic             last_src, last_src_nxt;
  logic [1:0]       grant_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_short_nxt, err_long_nxt;

  logic             src_valid, src_last, src_ready;
  logic [W-1:0]     src_data;
  logic             m_last_raw;
  logic             at_max, is_short;

  assign src_valid = sel ? S1_AXIS_TVALID : S0_AXIS_TVALID;
  assign src_last  = sel ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
  assign src_data  = sel ? S1_AXIS_TDATA  : S0_AXIS_TDATA;

  assign at_max   = (cnt == CNT_LAST);
  // A TLAST on the very first word means a one-word frame the framer can't take.
  assign is_short = (cnt == '0) && src_valid && src_last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ARB_IDLE;
      sel         <= 1'b0;
      last_src    <= 1'b1;  // source 0 wins the first tie
      o_grant     <= 2'b00;
      cnt         <= '0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      last_src    <= last_src_nxt;
      o_grant     <= grant_nxt;
      cnt         <= cnt_nxt;
      o_err_short <= err_short_nxt;
      o_err_long  <= err_long_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    last_src_nxt  = last_src;
    grant_nxt     = o_grant;
    cnt_nxt       = cnt;
    err_short_nxt = 1'b0;
    err_long_nxt  = 1'b0;
    src_ready     = 1'b0;
    M_AXIS_TVALID = 1'b0;
    m_last_raw    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
          sel_nxt      = (S0_AXIS_TVALID && S1_AXIS_TVALID) ? ~last_src : S1_AXIS_TVALID;
          last_src_nxt = sel_nxt;
          grant_nxt    = sel_nxt ? 2'b10 : 2'b01;
          cnt_nxt      = '0;
          state_nxt    = ARB_PASS;
        end
      end
      ARB_PASS: begin
        if (is_short) begin
          src_ready     = 1'b1;  // swallow it, framer never sees it
          err_short_nxt = 1'b1;
          grant_nxt     = 2'b00;
          state_nxt     = ARB_IDLE;
        end else begin
          M_AXIS_TVALID = src_valid;
          src_ready     = M_AXIS_TREADY;
          m_last_raw    = src_last || at_max;
          if (src_valid && M_AXIS_TREADY) begin
            if (at_max && !src_last) begin
              err_long_nxt = 1'b1;
              state_nxt    = ARB_DROP;
            end else if (src_last) begin
              grant_nxt = 2'b00;
              state_nxt = ARB_IDLE;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
      end
      ARB_DROP: begin
        src_ready = 1'b1;
        if (src_valid && src_last) begin
          grant_nxt = 2'b00;
          state_nxt = ARB_IDLE;
        end
      end
      default: begin
        grant_nxt = 2'b00;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign S0_AXIS_TREADY = src_ready && !sel;
  assign S1_AXIS_TREADY = src_ready &&  sel;

  assign M_AXIS_TDATA = (OPT_LOWPOWER && !M_AXIS_TVALID) ? '0   : src_data;
  assign M_AXIS_TLAST = (OPT_LOWPOWER && !M_AXIS_TVALID) ? 1'b0 : m_last_raw;

endmodule

// File: tb/tb_satalnk_txarb.sv
// Randomized self-checking bench for satalnk_txarb. Sources are driven from
// per-source frame-length plans; the reference model reasons per source word
// (index k in a frame of length L) to predict forwarding, forced TLAST and
// error pulses, and per idle cycle to predict the round-robin decision.
module tb_satalnk_txarb;

  localparam int W   = 32;
  localparam int MAX = 6;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          sv[2];
  logic [W-1:0]  sd[2];
  logic          sl[2];
  logic          s0r, s1r;
  logic          mv, mr, ml;
  logic [W-1:0]  md;
  logic [1:0]    o_grant;
  logic          err_short, err_long;

  always #5 clk = ~clk;

  satalnk_txarb #(.W(W), .MAX_WORDS(MAX), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .S0_AXIS_TVALID(sv[0]), .S0_AXIS_TREADY(s0r), .S0_AXIS_TDATA(sd[0]), .S0_AXIS_TLAST(sl[0]),
    .S1_AXIS_TVALID(sv[1]), .S1_AXIS_TREADY(s1r), .S1_AXIS_TDATA(sd[1]), .S1_AXIS_TLAST(sl[1]),
    .M_AXIS_TVALID(mv), .M_AXIS_TREADY(mr), .M_AXIS_TDATA(md), .M_AXIS_TLAST(ml),
    .o_grant(o_grant), .o_err_short(err_short), .o_err_long(err_long)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // source model state
  int   plan[2][$];
  bit   active[2];
  int   len[2], idx[2];
  bit   fire[2];
  int   vp = 100, rp = 100;

  // checker state
  bit         exp_short, exp_long, exp_idle;
  bit         have_pend, stalled, post_rst, do_reset;
  logic [1:0] pend;
  int         last_g = 1;
  logic [W-1:0] st_data;
  logic       st_last;

  task automatic monitor();
    logic [1:0] eg;
    logic f[2];
    bit fwd;
    fire[0] = 1'b0; fire[1] = 1'b0;
    if (i_reset) begin
      exp_short = 0; exp_long = 0; exp_idle = 0; have_pend = 0; stalled = 0;
      return;
    end
    if (post_rst) begin
      chk("rst_grant", o_grant, 0);
      chk("rst_ready", {s1r, s0r}, 0);
      chk("rst_mvalid", mv, 0);
      post_rst = 0;
    end
    chk("err_short", err_short, exp_short);
    chk("err_long", err_long, exp_long);
    if (have_pend) begin
      eg = (pend == 2'b11) ? (last_g == 1 ? 2'b01 : 2'b10) : pend;
      chk("rr_grant", o_grant, eg);
      if (eg != 2'b00) last_g = eg[1] ? 1 : 0;
    end
    if (exp_idle) chk("gap_idle", o_grant, 0);
    if (stalled) begin
      chk("stall_valid", mv, 1);
      chk("stall_data", md, st_data);
      chk("stall_last", ml, st_last);
    end
    case (o_grant)
      2'b00: begin chk("idle_ready", {s1r, s0r}, 0); chk("idle_mvalid", mv, 0); end
      2'b01: chk("s1_ready_off", s1r, 0);
      2'b10: chk("s0_ready_off", s0r, 0);
      default: chk("grant_onehot", o_grant, 0);
    endcase
    f[0] = sv[0] & s0r;
    f[1] = sv[1] & s1r;
    chk("one_src", f[0] & f[1], 0);
    exp_short = 0; exp_long = 0; exp_idle = 0;
    if (!f[0] && !f[1]) chk("no_src_mfire", mv & mr, 0);
    for (int s = 0; s < 2; s++) begin
      if (f[s]) begin
        fwd = (len[s] > 1) && (idx[s] < MAX);
        chk("owner", o_grant, (s == 1) ? 2 : 1);
        chk("forward", mv & mr, fwd);
        if (fwd) begin
          chk("data", md, sd[s]);
          chk("last", ml, (idx[s] == len[s]-1) || (idx[s] == MAX-1));
        end
        exp_short = (len[s] == 1);
        exp_long  = (len[s] > MAX) && (idx[s] == MAX-1);
        exp_idle  = (idx[s] == len[s]-1);
      end
    end
    stalled   = mv & ~mr;
    st_data   = md;
    st_last   = ml;
    have_pend = (o_grant == 2'b00);
    pend      = {sv[1], sv[0]};
    fire[0]   = f[0];
    fire[1]   = f[1];
  endtask

  task automatic drive();
    if (i_reset) begin
      for (int s = 0; s < 2; s++) begin
        active[s] = 0; idx[s] = 0; sv[s] = 0; sl[s] = 0;
      end
      i_reset = 1'b0;
      post_rst = 1;
      last_g = 1;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (fire[s]) begin
          idx[s]++;
          sv[s] = 0;
          if (idx[s] == len[s]) active[s] = 0;
        end
        if (!active[s] && plan[s].size() > 0) begin
          len[s] = plan[s].pop_front();
          idx[s] = 0;
          active[s] = 1;
        end
        if (active[s] && !sv[s] && ($urandom % 100) < vp) begin
          sv[s] = 1;
          sd[s] = (len[s] == 1) ? 32'hDEADBEEF : $urandom;
          sl[s] = (idx[s] == len[s]-1);
        end
      end
    end
    if (do_reset) begin
      i_reset = 1'b1;
      do_reset = 0;
    end
    mr = (($urandom % 100) < rp);
  endtask

  task automatic cycle();
    @(negedge clk); monitor();
    @(posedge clk); #1; drive();
  endtask

  task automatic run_done(input int bound);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(plan[0].size() == 0 && plan[1].size() == 0 && !active[0] && !active[1]) && n < bound);
    chk("timeout", n < bound, 1);
    repeat (3) cycle();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      sv[s] = 0; sd[s] = '0; sl[s] = 0; active[s] = 0; len[s] = 0; idx[s] = 0;
    end
    mr = 1'b1;
    cycle();  // reset cycle

    // tie after reset: source 0 first, then source 1
    plan[0].push_back(3); plan[1].push_back(3);
    run_done(200);

    // source 1 streams frames while source 0 sends one
    repeat (5) plan[1].push_back(4);
    plan[0].push_back(4);
    run_done(400);

    // single-word frame then a normal frame
    plan[0].push_back(1); plan[0].push_back(3);
    run_done(200);

    // over-length frame plus competing traffic
    plan[0].push_back(9); plan[1].push_back(2);
    run_done(200);

    // backpressure on a 10-word frame, other source also requesting
    rp = 50;
    plan[0].push_back(10); plan[1].push_back(3);
    run_done(400);

    // random mix
    vp = 60; rp = 70;
    for (int i = 0; i < 40; i++) begin
      plan[0].push_back($urandom_range(1, 10));
      plan[1].push_back($urandom_range(1, 10));
    end
    run_done(6000);

    // reset in the middle of a frame
    vp = 100; rp = 100;
    plan[0].push_back(6);
    begin
      int n = 0;
      do begin cycle(); n++; end while (!(active[0] && idx[0] == 2) && n < 100);
      chk("rst_wait", n < 100, 1);
    end
    do_reset = 1;
    cycle();  // reset asserted
    cycle();  // reset takes effect
    plan[0].push_back(2); plan[1].push_back(2);
    run_done(200);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
